// File: rtl/cpu_dbg_pkg.sv
// Shared debug-path constants and the register-dump FSM state type.
package cpu_dbg_pkg;

  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    FETCH   = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4,
    CSUM    = 3'd5,
    DONE    = 3'd6
  } dump_state_e;

endpackage

// File: rtl/reg_dump_unit_byte_tx_stage.sv
// Registered valid/ready output stage; a byte once offered is held until accepted.
module byte_tx_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       fire
);

  assign fire = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load && (!tx_valid || tx_ready)) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (fire) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_dump_unit.sv
// Streams R0..R7 as a byte frame (header, hi/lo per register, optional checksum).
// Define REG_DUMP_CSUM_EN to append the modulo-256 checksum byte.
module reg_dump_unit
  import cpu_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        word_lo;
  logic              load;
  logic [7:0]        load_data;
  logic              fire;
  logic              last;
`ifdef REG_DUMP_CSUM_EN
  logic [7:0]        sum;
`endif

  assign last    = (idx == IDX_LAST);
  assign rd_addr = idx;
  assign busy    = (state != IDLE);

  // The next byte is loaded into the output stage on the same edge the
  // previous one transfers, so each register costs exactly three cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      word_lo <= '0;
`ifdef REG_DUMP_CSUM_EN
      sum     <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          idx <= '0;
`ifdef REG_DUMP_CSUM_EN
          sum <= '0;
`endif
        end
        FETCH: word_lo <= rd_data[7:0];
`ifdef REG_DUMP_CSUM_EN
        SEND_HI: if (fire) sum <= sum + tx_data;
`endif
        SEND_LO: if (fire) begin
`ifdef REG_DUMP_CSUM_EN
          sum <= sum + tx_data;
`endif
          if (!last) idx <= idx + ADDR_W'(1);
        end
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    load_data = '0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx  = HDR;
        load      = 1'b1;
        load_data = HDR_BYTE;
      end
      HDR: if (fire) state_nx = FETCH;
      FETCH: begin
        state_nx  = SEND_HI;
        load      = 1'b1;
        load_data = rd_data[15:8];
      end
      SEND_HI: if (fire) begin
        state_nx  = SEND_LO;
        load      = 1'b1;
        load_data = word_lo;
      end
      SEND_LO: if (fire) begin
        if (last) begin
`ifdef REG_DUMP_CSUM_EN
          state_nx  = CSUM;
          load      = 1'b1;
          load_data = sum + tx_data;
`else
          state_nx  = DONE;
`endif
        end else begin
          state_nx = FETCH;
        end
      end
`ifdef REG_DUMP_CSUM_EN
      CSUM: if (fire) state_nx = DONE;
`endif
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  byte_tx_stage u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .fire      (fire)
  );

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed and randomized frame checks for reg_dump_unit against a frame-level model.
module tb_reg_dump_unit;

`ifdef REG_DUMP_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int FRAME_CYC = CSUM_EN ? 27 : 26;

  logic        clk = 1'b0;
  logic        reset, start, tx_ready;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  logic [15:0] regs [8];
  logic [15:0] snap [8];

  always #5 clk = ~clk;

  // Register file read port 2: R0 reads as zero regardless of contents.
  assign rd_data = (rd_addr == 3'd0) ? 16'h0000 : regs[rd_addr];

  reg_dump_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int fails  = 0;

  logic [7:0] got[$];
  logic [2:0] addrs[$];
  int busy_cycles, done_cnt, done_at, stalls, stab_err, guard;
  bit aborted;
  int wr_cyc [2];
  int wr_a   [2];
  logic [15:0] wr_v [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 = always ready, 1 = toggling, 2 = random
  task automatic run_frame(input int rmode, input int abort_at, input bit mid_start,
                           input bit done_start);
    bit         prev_stall;
    logic [7:0] prev_data;
    got.delete();
    addrs.delete();
    busy_cycles = 0; done_cnt = 0; done_at = 0; stalls = 0; stab_err = 0; guard = 0;
    aborted = 1'b0; prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    start = 1'b1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (mid_start && busy_cycles == 9) start = 1'b1;
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = guard[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      for (int k = 0; k < 2; k++)
        if (wr_cyc[k] == busy_cycles + 1) regs[wr_a[k]] = wr_v[k];
      if (abort_at > 0 && got.size() == abort_at && tx_valid) begin
        reset   = 1'b1;
        aborted = 1'b1;
        break;
      end
      #1;
      if (!busy) break;
      busy_cycles++;
      if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && !tx_ready) stalls++;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (!tx_valid && !done) addrs.push_back(rd_addr);
      if (done) begin
        done_cnt++;
        done_at = busy_cycles;
        if (done_start) start = 1'b1;
      end
      if (guard > 400) break;
    end
    chk("frame_bound", 32'(guard > 400), 32'd0);
  endtask

  task automatic take_snapshot();
    for (int r = 0; r < 8; r++) snap[r] = regs[r];
    snap[0] = 16'h0000;
  endtask

  task automatic check_frame(input string name, input bit check_addrs);
    logic [7:0] exp[$];
    logic [7:0] s;
    s = 8'h00;
    exp.push_back(8'hA5);
    for (int r = 0; r < 8; r++) begin
      exp.push_back(snap[r][15:8]);
      exp.push_back(snap[r][7:0]);
      s = s + snap[r][15:8] + snap[r][7:0];
    end
    if (CSUM_EN) exp.push_back(s);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_byte%0d", name, i),
          {24'h0, (i < got.size()) ? got[i] : 8'hxx}, {24'h0, exp[i]});
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({name, "_done_last"}, 32'(done_at), 32'(busy_cycles));
    chk({name, "_cycles"}, 32'(busy_cycles), 32'(FRAME_CYC + stalls));
    chk({name, "_stable"}, 32'(stab_err), 32'd0);
    if (check_addrs) begin
      chk({name, "_naddr"}, 32'(addrs.size()), 32'd8);
      for (int r = 0; r < 8; r++)
        chk($sformatf("%s_addr%0d", name, r),
            {29'h0, (r < addrs.size()) ? addrs[r] : 3'bxxx}, 32'(r));
    end
  endtask

  task automatic randomize_regs();
    for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
    for (int r = 0; r < 8; r++) regs[r] = 16'h0000;
    for (int k = 0; k < 2; k++) begin wr_cyc[k] = 0; wr_a[k] = 0; wr_v[k] = '0; end

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_rd_addr", {29'h0, rd_addr}, 32'd0);
    reset = 1'b0;

    take_snapshot();
    run_frame(0, 0, 1'b0, 1'b0);
    check_frame("zero", 1'b1);

    regs[1] = 16'h1234;
    take_snapshot();
    run_frame(0, 0, 1'b1, 1'b1);
    check_frame("r1", 1'b1);
    chk("r1_idle_after", {31'h0, busy}, 32'd0);

    regs[1] = 16'h0000; regs[6] = 16'h0102; regs[7] = 16'hFFFF;
    take_snapshot();
    run_frame(0, 0, 1'b0, 1'b0);
    check_frame("r67", 1'b0);

    // R7 rewritten before its fetch shows up; R1 rewritten after its fetch does not.
    take_snapshot();
    snap[7] = 16'hABCD;
    wr_cyc[0] = 5;  wr_a[0] = 7; wr_v[0] = 16'hABCD;
    wr_cyc[1] = 15; wr_a[1] = 1; wr_v[1] = 16'h5555;
    run_frame(0, 0, 1'b0, 1'b0);
    check_frame("live_wr", 1'b0);
    wr_cyc[0] = 0; wr_cyc[1] = 0;

    randomize_regs();
    take_snapshot();
    run_frame(1, 0, 1'b0, 1'b0);
    check_frame("toggle", 1'b0);

    randomize_regs();
    run_frame(0, 7, 1'b0, 1'b0);
    chk("abort_reached", {31'h0, aborted}, 32'd1);
    @(negedge clk);
    #1;
    chk("abort_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_no_done_pulse", 32'(done_cnt), 32'd0);
    reset = 1'b0;
    take_snapshot();
    run_frame(2, 0, 1'b0, 1'b0);
    check_frame("post_abort", 1'b1);

    for (int n = 0; n < 3; n++) begin
      randomize_regs();
      take_snapshot();
      run_frame(2, 0, 1'b0, 1'b0);
      check_frame($sformatf("rand%0d", n), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
